// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of the single-port
// data memory (r0 = CPU load/store, r1 = DMA/debug loader).
//
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   rN_req/we/lock        request, write enable, lock request
//   rN_addr/wdata         byte address, write data
//   rN_gnt                combinational grant (access happens this cycle)
//   rN_rvalid/rdata/err   registered response, one cycle after grant
//   Address/WriteData     memory address and write data
//   MemWrite/MemRead      memory strobes
//   ReadData              combinational memory read data
//
// Build option: define ARB_LOCK_EN to enable the lock FSM (IDLE/OWN0/OWN1)
// with an idle timeout of LOCK_TIMEOUT cycles. Without it, lock inputs are
// ignored and arbitration is pure round-robin.

module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_WORDS    = 1024,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] ReadData
);

    localparam logic [ADDR_W-1:0] WORD_LIMIT = ADDR_W'(MEM_WORDS);

    // Misaligned or word index past the end of memory.
    function automatic logic bad_addr(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) ||
               ({2'b00, a[ADDR_W-1:2]} >= WORD_LIMIT);
    endfunction

    logic              r0_bad;
    logic              r1_bad;
    logic              allow0;
    logic              allow1;
    logic              g0;
    logic              g1;

    logic              last_gnt_q;
    logic              last_gnt_d;
    logic              r0_rvalid_q, r0_rvalid_d;
    logic              r1_rvalid_q, r1_rvalid_d;
    logic              r0_err_q, r0_err_d;
    logic              r1_err_q, r1_err_d;
    logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

    assign r0_bad = bad_addr(r0_addr);
    assign r1_bad = bad_addr(r1_addr);

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } lock_e;

    localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    lock_e             lock_q;
    lock_e             lock_d;
    lock_e             lock_eff;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              expired;

    // An owner idle for the full timeout releases the lock in the same
    // cycle, so the other requester can be granted right away.
    always_comb begin
        expired = 1'b0;
        unique case (lock_q)
            OWN0:    expired = !r0_req && (cnt_q == CNT_LAST);
            OWN1:    expired = !r1_req && (cnt_q == CNT_LAST);
            default: expired = 1'b0;
        endcase
        lock_eff = expired ? IDLE : lock_q;
        allow0   = (lock_eff != OWN1);
        allow1   = (lock_eff != OWN0);
    end

    always_comb begin
        lock_d = lock_eff;
        cnt_d  = cnt_q;
        unique case (lock_eff)
            OWN0: begin
                if (g0) begin
                    cnt_d = '0;
                    if (!r0_lock) lock_d = IDLE;
                end else if (!r0_req) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OWN1: begin
                if (g1) begin
                    cnt_d = '0;
                    if (!r1_lock) lock_d = IDLE;
                end else if (!r1_req) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
                if (g0 && r0_lock) lock_d = OWN0;
                else if (g1 && r1_lock) lock_d = OWN1;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lock_q <= IDLE;
            cnt_q  <= '0;
        end else begin
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = r0_lock ^ r1_lock;
    assign allow0 = 1'b1;
    assign allow1 = 1'b1;
`endif

    // Round-robin: on a conflict the requester that was not granted last
    // wins. Reset masks all grants so the memory lines go idle at once.
    always_comb begin
        logic q0;
        logic q1;
        q0 = r0_req && allow0 && !Reset;
        q1 = r1_req && allow1 && !Reset;
        g0 = 1'b0;
        g1 = 1'b0;
        if (q0 && q1) begin
            g0 = last_gnt_q;
            g1 = !last_gnt_q;
        end else begin
            g0 = q0;
            g1 = q1;
        end
    end

    assign r0_gnt = g0;
    assign r1_gnt = g1;

    always_comb begin
        Address   = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        if (g0) begin
            Address   = r0_addr;
            WriteData = r0_wdata;
            MemWrite  = r0_we && !r0_bad;
            MemRead   = !r0_we && !r0_bad;
        end else if (g1) begin
            Address   = r1_addr;
            WriteData = r1_wdata;
            MemWrite  = r1_we && !r1_bad;
            MemRead   = !r1_we && !r1_bad;
        end
    end

    // Responses: reads and rejected accesses produce rvalid; rdata holds
    // its value until the next response and is zero on a rejection.
    always_comb begin
        last_gnt_d  = last_gnt_q;
        if (g0) last_gnt_d = 1'b0;
        if (g1) last_gnt_d = 1'b1;

        r0_rvalid_d = g0 && (!r0_we || r0_bad);
        r0_err_d    = g0 && r0_bad;
        r0_rdata_d  = r0_rdata_q;
        if (g0 && r0_bad) r0_rdata_d = '0;
        else if (g0 && !r0_we) r0_rdata_d = ReadData;

        r1_rvalid_d = g1 && (!r1_we || r1_bad);
        r1_err_d    = g1 && r1_bad;
        r1_rdata_d  = r1_rdata_q;
        if (g1 && r1_bad) r1_rdata_d = '0;
        else if (g1 && !r1_we) r1_rdata_d = ReadData;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_gnt_q  <= 1'b1;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_err_q    <= 1'b0;
            r1_err_q    <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            r0_rvalid_q <= r0_rvalid_d;
            r1_rvalid_q <= r1_rvalid_d;
            r0_err_q    <= r0_err_d;
            r1_err_q    <= r1_err_d;
            r0_rdata_q  <= r0_rdata_d;
            r1_rdata_q  <= r1_rdata_d;
        end
    end

    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_err    = r0_err_q;
    assign r1_err    = r1_err_q;
    assign r0_rdata  = r0_rdata_q;
    assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// 1024-word memory (combinational read, posedge write).

module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        r0_req, r0_we, r0_lock;
    logic [31:0] r0_addr, r0_wdata;
    logic        r0_gnt, r0_rvalid, r0_err;
    logic [31:0] r0_rdata;
    logic        r1_req, r1_we, r1_lock;
    logic [31:0] r1_addr, r1_wdata;
    logic        r1_gnt, r1_rvalid, r1_err;
    logic [31:0] r1_rdata;
    logic [31:0] Address, WriteData, ReadData;
    logic        MemWrite, MemRead;

    int n_chk = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_WORDS(1024), .LOCK_TIMEOUT(16)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .r1_rdata(r1_rdata), .r1_err(r1_err),
        .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead),
        .ReadData(ReadData)
    );

    logic [31:0] mem [1024];
    logic        mem_init;

    assign ReadData = mem[Address[11:2]];

    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        end else if (MemWrite) begin
            mem[Address[11:2]] <= WriteData;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic mid();
        @(negedge Clk);
    endtask

    task automatic idle();
        r0_req = 0; r0_we = 0; r0_lock = 0;
        r1_req = 0; r1_we = 0; r1_lock = 0;
    endtask

    task automatic rq0(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic lk);
        r0_req = 1; r0_we = we; r0_addr = a; r0_wdata = d; r0_lock = lk;
    endtask

    task automatic rq1(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic lk);
        r1_req = 1; r1_we = we; r1_addr = a; r1_wdata = d; r1_lock = lk;
    endtask

    initial begin
        idle();
        r0_addr = 0; r0_wdata = 0; r1_addr = 0; r1_wdata = 0;
        Reset = 1;
        mem_init = 1;
        rq0(0, 32'h10, 0, 0);
        rq1(0, 32'h14, 0, 0);
        repeat (2) @(posedge Clk);
        #1 mem_init = 0;

        // Requests present during reset are not granted.
        mid();
        chk("rst_rvalid0", 32'(r0_rvalid), 0);
        chk("rst_err1", 32'(r1_err), 0);
        chk("rst_rdata0", r0_rdata, 0);
        chk("rst_gnt0", 32'(r0_gnt), 0);
        chk("rst_memread", 32'(MemRead), 0);
        chk("rst_addr", Address, 0);
        tick();
        Reset = 0;
        idle();

        // Single requester: write then read back.
        rq0(1, 32'h10, 32'hDEADBEEF, 0);
        mid();
        chk("wr_gnt0", 32'(r0_gnt), 1);
        chk("wr_memwrite", 32'(MemWrite), 1);
        chk("wr_memread", 32'(MemRead), 0);
        chk("wr_addr", Address, 32'h10);
        chk("wr_wdata", WriteData, 32'hDEADBEEF);
        tick();
        rq0(0, 32'h10, 0, 0);
        mid();
        chk("rd_memread", 32'(MemRead), 1);
        chk("rd_memwrite", 32'(MemWrite), 0);
        chk("wr_no_rvalid", 32'(r0_rvalid), 0);
        tick();
        idle();
        rq1(1, 32'h14, 32'h12345678, 0);
        mid();
        chk("rd_rvalid0", 32'(r0_rvalid), 1);
        chk("rd_rdata0", r0_rdata, 32'hDEADBEEF);
        chk("pre_gnt1", 32'(r1_gnt), 1);
        tick();
        rq1(1, 32'h0, 32'h11111111, 0);
        mid();
        chk("rvalid0_pulse", 32'(r0_rvalid), 0);
        chk("rdata0_hold", r0_rdata, 32'hDEADBEEF);
        chk("idle_r1_rvalid", 32'(r1_rvalid), 0);
        tick();
        idle();
        mid();
        chk("idle_addr", Address, 0);
        chk("idle_wdata", WriteData, 0);
        chk("idle_memwrite", 32'(MemWrite), 0);
        tick();

        // Reset in the middle of a pending response.
        rq0(0, 32'h10, 0, 0);
        tick();
        rq1(0, 32'h14, 0, 0);
        #1 Reset = 1;
        mid();
        chk("mrst_rvalid0", 32'(r0_rvalid), 0);
        chk("mrst_rdata0", r0_rdata, 0);
        chk("mrst_gnt1", 32'(r1_gnt), 0);
        chk("mrst_memread", 32'(MemRead), 0);
        chk("mrst_addr", Address, 0);
        tick();
        Reset = 0;

        // Conflict: both read continuously; r0 wins first after reset.
        for (int i = 0; i < 6; i++) begin
            mid();
            chk($sformatf("cf%0d_gnt0", i), 32'(r0_gnt), 32'(i % 2 == 0));
            chk($sformatf("cf%0d_gnt1", i), 32'(r1_gnt), 32'(i % 2 == 1));
            if (i > 0) begin
                chk($sformatf("cf%0d_rv0", i), 32'(r0_rvalid),
                    32'(i % 2 == 1));
                chk($sformatf("cf%0d_rv1", i), 32'(r1_rvalid),
                    32'(i % 2 == 0));
                if (i % 2 == 1) chk($sformatf("cf%0d_rd0", i), r0_rdata,
                                    32'hDEADBEEF);
                else chk($sformatf("cf%0d_rd1", i), r1_rdata,
                         32'h12345678);
            end
            tick();
        end
        idle();
        mid();
        chk("cf_last_rv1", 32'(r1_rvalid), 1);
        chk("cf_last_rd1", r1_rdata, 32'h12345678);
        chk("cf_last_rv0", 32'(r0_rvalid), 0);
        tick();

        // Rejected accesses: misaligned read, out-of-range write.
        rq1(0, 32'h1002, 0, 0);
        mid();
        chk("mis_gnt1", 32'(r1_gnt), 1);
        chk("mis_memread", 32'(MemRead), 0);
        chk("mis_memwrite", 32'(MemWrite), 0);
        tick();
        rq1(1, 32'h1000, 32'hBAD0BAD0, 0);
        mid();
        chk("oor_gnt1", 32'(r1_gnt), 1);
        chk("oor_memwrite", 32'(MemWrite), 0);
        chk("mis_rvalid1", 32'(r1_rvalid), 1);
        chk("mis_err1", 32'(r1_err), 1);
        chk("mis_rdata1", r1_rdata, 0);
        tick();
        idle();
        rq0(0, 32'h0, 0, 0);
        mid();
        chk("oor_rvalid1", 32'(r1_rvalid), 1);
        chk("oor_err1", 32'(r1_err), 1);
        chk("rb_gnt0", 32'(r0_gnt), 1);
        tick();
        idle();
        rq1(0, 32'hFFC, 0, 0);
        mid();
        chk("rb_rvalid0", 32'(r0_rvalid), 1);
        chk("rb_rdata0", r0_rdata, 32'h11111111);
        chk("rb_err0", 32'(r0_err), 0);
        chk("top_memread", 32'(MemRead), 1);
        tick();
        idle();
        mid();
        chk("top_rvalid1", 32'(r1_rvalid), 1);
        chk("top_err1", 32'(r1_err), 0);
        tick();

`ifdef ARB_LOCK_EN
        // Lock held by r0 until it releases with an unlocked write.
        rq0(0, 32'h20, 0, 1);
        rq1(0, 32'h14, 0, 0);
        mid();
        chk("lk0_gnt0", 32'(r0_gnt), 1);
        chk("lk0_gnt1", 32'(r1_gnt), 0);
        tick();
        mid();
        chk("lk1_gnt0", 32'(r0_gnt), 1);
        chk("lk1_gnt1", 32'(r1_gnt), 0);
        tick();
        r0_req = 0;
        mid();
        chk("lk2_gnt1", 32'(r1_gnt), 0);
        tick();
        rq0(1, 32'h20, 32'hCAFEF00D, 0);
        mid();
        chk("lk3_gnt0", 32'(r0_gnt), 1);
        chk("lk3_gnt1", 32'(r1_gnt), 0);
        tick();
        r0_req = 0;
        mid();
        chk("lk4_gnt1", 32'(r1_gnt), 1);
        tick();

        // Lock timeout: r1 waits exactly 16 cycles after r0's last grant.
        rq0(0, 32'h20, 0, 1);
        mid();
        chk("to_gnt0", 32'(r0_gnt), 1);
        tick();
        r0_req = 0;
        r0_lock = 0;
        for (int k = 1; k < 16; k++) begin
            mid();
            chk($sformatf("to%0d_gnt1", k), 32'(r1_gnt), 0);
            tick();
        end
        mid();
        chk("to16_gnt1", 32'(r1_gnt), 1);
        tick();
        idle();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
